// File: rtl/bcd_timer_pkg.sv
// ----------------------------------------------------------------------------
// bcd_timer_pkg
// Shared types and helpers for the two-digit BCD timer controller.
//   state_t      : controller FSM states
//   BCD_MAX      : largest legal BCD digit
//   bcd_clamp()  : folds 10..15 down to 9
//   bcd_to_load(): 8-bit async set/clear pattern that forces a counter to d
// ----------------------------------------------------------------------------
package bcd_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   // For Q[k], k = 1..4: bit 2k-2 sets it, bit 2k-1 clears it, so each
   // bit pair is {~d, d}.
   function automatic logic [7:0] bcd_to_load(input logic [3:0] d);
      return {~d[3], d[3], ~d[2], d[2], ~d[1], d[1], ~d[0], d[0]};
   endfunction

endpackage

// File: rtl/bcd_timer_ctrl_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running 0..TICK_DIV-1 step pacer for the BCD timer.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; count returns to 0
//   clear : synchronous clear to 0 (has priority over run)
//   run   : count advances only while high; otherwise the count is frozen
//   tick  : high while the count sits at TICK_DIV-1
// ----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (run) begin
         if (r_cnt == LAST) r_cnt <= '0;
         else               r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_timer_ctrl
// Sequencer for an external two-digit chain of 0-9 BCD counters: presets the
// digits, paces steps with a prescaler, cascades ones carry/borrow into the
// tens enable, supports pause and stops exactly on the terminal count.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : level, (re)starts a run; captures preset/up_down
//   pause                 : level, freezes counting while high
//   up_down               : 1 = count 00 -> preset, 0 = preset -> 00
//   preset_tens/ones      : BCD preset or target, 10..15 clamp to 9
//   q_tens/q_ones [4:1]   : counter digit outputs, Q[1] is the LSB
//   en_tens/en_ones       : counter enables
//   rev                   : counter direction, 1 = count down
//   load_tens/load_ones   : async set/clear lines, one-cycle pulse in LOAD
//   busy, done            : status (LOAD/RUN/PAUSE, DONE)
//   dbg_state             : current FSM state for observation
//
// Handshake: start and pause are plain levels sampled every rising edge;
// enables are combinational and only meaningful at the rising edge that
// follows them; no ready/acknowledge path exists.
// ----------------------------------------------------------------------------
module bcd_timer_ctrl
   import bcd_timer_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       up_down,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_ones,
   input  logic [4:1] q_tens,
   input  logic [4:1] q_ones,
   output logic       en_tens,
   output logic       en_ones,
   output logic       rev,
   output logic [7:0] load_tens,
   output logic [7:0] load_ones,
   output logic       busy,
   output logic       done,
   output state_t     dbg_state
);

   state_t     r_state;
   logic       r_up;
   logic [3:0] r_tgt_tens;
   logic [3:0] r_tgt_ones;
   logic [7:0] r_load_tens;
   logic [7:0] r_load_ones;
   logic       r_rev;
   logic       r_busy;
   logic       r_done;

   logic [3:0] w_q_tens;
   logic [3:0] w_q_ones;
   logic       w_term;
   logic       w_run;
   logic       w_tick;
   logic       w_go_load;
   logic [3:0] w_cl_tens;
   logic [3:0] w_cl_ones;

   assign w_q_tens  = q_tens;
   assign w_q_ones  = q_ones;
   assign w_cl_tens = bcd_clamp(preset_tens);
   assign w_cl_ones = bcd_clamp(preset_ones);

   assign w_term = r_up ? ((w_q_tens == r_tgt_tens) && (w_q_ones == r_tgt_ones))
                        : ((w_q_tens == 4'd0) && (w_q_ones == 4'd0));

   // Pause gates the prescaler and the enables in the same cycle it rises,
   // so a tick coinciding with the pause edge is held rather than lost.
   assign w_run = (r_state == ST_RUN) && !pause;

   // A start arriving during the one-cycle LOAD is ignored so the load
   // pulse always lasts exactly one cycle.
   assign w_go_load = start && (r_state != ST_LOAD);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (r_state == ST_LOAD),
      .run   (w_run),
      .tick  (w_tick)
   );

   assign en_ones = w_run && w_tick && !w_term;
   assign en_tens = en_ones && (r_up ? (w_q_ones == BCD_MAX) : (w_q_ones == 4'd0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_up        <= 1'b0;
         r_tgt_tens  <= 4'd0;
         r_tgt_ones  <= 4'd0;
         r_load_tens <= 8'h00;
         r_load_ones <= 8'h00;
         r_rev       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_load_tens <= 8'h00;
         r_load_ones <= 8'h00;
         if (w_go_load) begin
            r_state     <= ST_LOAD;
            r_up        <= up_down;
            r_tgt_tens  <= w_cl_tens;
            r_tgt_ones  <= w_cl_ones;
            // Up mode always starts from 00; the preset is its target.
            r_load_tens <= up_down ? bcd_to_load(4'd0) : bcd_to_load(w_cl_tens);
            r_load_ones <= up_down ? bcd_to_load(4'd0) : bcd_to_load(w_cl_ones);
            r_rev       <= !up_down;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  if (w_term) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (pause) begin
                     r_state <= ST_PAUSE;
                  end
               end
               ST_PAUSE: begin
                  if (!pause) r_state <= ST_RUN;
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   assign load_tens = r_load_tens;
   assign load_ones = r_load_ones;
   assign rev       = r_rev;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
module tb_bcd_timer_ctrl;
  import bcd_timer_pkg::*;

  localparam int TICK_DIV = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start, pause, up_down;
  logic [3:0] preset_tens, preset_ones;
  logic [4:1] q_tens, q_ones;
  logic       en_tens, en_ones, rev, busy, done;
  logic [7:0] load_tens, load_ones;
  state_t     dbg_state;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .up_down(up_down),
    .preset_tens(preset_tens), .preset_ones(preset_ones),
    .q_tens(q_tens), .q_ones(q_ones),
    .en_tens(en_tens), .en_ones(en_ones), .rev(rev),
    .load_tens(load_tens), .load_ones(load_ones),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- two real 0-9 counters with async set/clear ----------------
  logic ld_t_any, ld_o_any;
  assign ld_t_any = |load_tens;
  assign ld_o_any = |load_ones;

  function automatic logic [4:1] apply_load(input logic [4:1] q, input logic [7:0] ld);
    logic [4:1] r;
    r = q;
    for (int k = 1; k <= 4; k++) begin
      if (ld[2*k-2])      r[k] = 1'b1;
      else if (ld[2*k-1]) r[k] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [4:1] bcd_step(input logic [4:1] q, input logic down);
    if (down) return (q == 4'd0) ? 4'd9 : q - 4'd1;
    else      return (q == 4'd9) ? 4'd0 : q + 4'd1;
  endfunction

  always @(posedge clk or posedge ld_t_any) begin
    if (ld_t_any)     q_tens <= apply_load(q_tens, load_tens);
    else if (en_tens) q_tens <= bcd_step(q_tens, rev);
  end

  always @(posedge clk or posedge ld_o_any) begin
    if (ld_o_any)     q_ones <= apply_load(q_ones, load_ones);
    else if (en_ones) q_ones <= bcd_step(q_ones, rev);
  end

  // ---------------- scoreboard ----------------
  // event word: {5'b0, type[2:0], a[7:0], b[7:0], c[7:0]}
  //   type 1 load : a=load_tens b=load_ones c={busy,rev}
  //   type 2 step : a=q before step (BCD) b={busy,en_tens,rev} c=cycles since last event
  //   type 3 done : a=q (BCD) b={busy} c=cycles since last event
  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] ev(input logic [2:0] t, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c);
    return {5'b0, t, a, b, c};
  endfunction

  // reference model: plain decimal arithmetic on the digit value
  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] pattern_of(input int d);
    logic [3:0] b;
    logic [7:0] r;
    b = 4'(d);
    for (int k = 0; k < 4; k++) begin
      r[2*k]   = b[k];
      r[2*k+1] = !b[k];
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push_model(input logic up, input logic [3:0] pt, input logic [3:0] po,
                            input int limit, input int pause_idx, input int pause_extra);
    int n, steps, v, g;
    logic [7:0] lt, lo;
    logic cas;
    n  = 10 * clamp9(pt) + clamp9(po);
    lt = up ? 8'hAA : pattern_of(clamp9(pt));
    lo = up ? 8'hAA : pattern_of(clamp9(po));
    exp_q.push_back(ev(3'd1, lt, lo, {6'b0, 1'b1, !up}));
    steps = (limit >= 0) ? limit : n;
    for (int s = 0; s < steps; s++) begin
      v   = up ? s : n - s;
      cas = up ? ((v % 10) == 9) : ((v % 10) == 0);
      g   = TICK_DIV + ((s == pause_idx) ? pause_extra : 0);
      exp_q.push_back(ev(3'd2, bcd8(v), {5'b0, 1'b1, cas, !up}, 8'(g)));
    end
    if (limit < 0) exp_q.push_back(ev(3'd3, bcd8(up ? n : 0), 8'h00, 8'd2));
  endtask

  task automatic sb_check(input logic [31:0] got);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected type=%0d got=%h expected no event", got[26:24], got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL sb_event type=%0d got=%h exp=%h", e[26:24], got, e);
      end
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  int cyc = 0;
  int last_ref = 0;
  logic done_q = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (load_tens != 8'h00 || load_ones != 8'h00) begin
          sb_check(ev(3'd1, load_tens, load_ones, {6'b0, busy, rev}));
          last_ref = cyc;
        end
        if (en_ones || en_tens) begin
          sb_check(ev(3'd2, {q_tens, q_ones}, {5'b0, busy, en_tens, rev}, 8'(cyc - last_ref)));
          last_ref = cyc;
        end
        if (done && !done_q)
          sb_check(ev(3'd3, {q_tens, q_ones}, {7'b0, busy}, 8'(cyc - last_ref)));
      end
      done_q = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic up, input logic [3:0] pt, input logic [3:0] po);
    @(posedge clk); #1;
    up_down = up; preset_tens = pt; preset_ones = po; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_pause(input int j, input int plen);
    repeat (j) begin @(posedge clk); #1; end
    pause = 1'b1;
    repeat (plen) begin @(posedge clk); #1; end
    pause = 1'b0;
  endtask

  // waits at falling edges until `steps` enables were seen (steps<0: until done)
  task automatic wait_run(input int steps, input int pa, input int plen, input int pj,
                          input string name);
    int seen;
    logic fin;
    seen = 0;
    fin  = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (en_ones) begin
        seen++;
        if (seen == pa) do_pause(pj, plen);
        if (steps >= 0 && seen == steps) fin = 1'b1;
      end
      if (steps < 0 && done) fin = 1'b1;
    end
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL %s timeout got=%0d enables, required completion", name, seen);
    end
  endtask

  task automatic run_case(input logic up, input logic [3:0] pt, input logic [3:0] po,
                          input int pa, input int plen, input int pj, input string name);
    push_model(up, pt, po, -1, pa, plen + 1);
    drive_start(up, pt, po);
    wait_run(-1, pa, plen, pj, name);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    logic [20:0] outs;
    outs = {en_tens, en_ones, rev, load_tens, load_ones, busy, done};
    tests++;
    if (outs !== 21'd0) begin
      fails++;
      $display("FAIL %s outputs got=%h required=0", name, outs);
    end
    tests++;
    if (dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL %s state got=%0d required=%0d", name, dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic       r_up;
    logic [3:0] r_pt, r_po;
    int         n, pa, plen, pj;

    reset = 1'b1; start = 1'b0; pause = 1'b0; up_down = 1'b0;
    preset_tens = 4'd0; preset_ones = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    run_case(1'b0, 4'd2, 4'd5, -1, 0, 0, "down_25");
    run_case(1'b1, 4'd1, 4'd2, -1, 0, 0, "up_12");
    // 8 steps (25..18) leave q=17, then pause 10 cycles
    run_case(1'b0, 4'd2, 4'd5, 8, 10, 2, "pause_at_17");
    run_case(1'b0, 4'd2, 4'd5, 8, 10, TICK_DIV, "pause_on_tick");
    run_case(1'b0, 4'd0, 4'd0, -1, 0, 0, "down_00");
    run_case(1'b1, 4'd0, 4'd0, -1, 0, 0, "up_00");
    run_case(1'b0, 4'hF, 4'hC, -1, 0, 0, "clamp_99");

    // restart: 27 steps (40..14) leave q=13, then start again with preset 40
    push_model(1'b0, 4'd4, 4'd0, 27, -1, 0);
    drive_start(1'b0, 4'd4, 4'd0);
    wait_run(27, -1, 0, 0, "restart_pre");
    push_model(1'b0, 4'd4, 4'd0, -1, -1, 0);
    drive_start(1'b0, 4'd4, 4'd0);
    wait_run(-1, -1, 0, 0, "restart_run");
    repeat (6) @(negedge clk);

    // async reset between edges mid-run, then a fresh start
    push_model(1'b0, 4'd3, 4'd7, 5, -1, 0);
    drive_start(1'b0, 4'd3, 4'd7);
    wait_run(5, -1, 0, 0, "reset_pre");
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    run_case(1'b0, 4'd3, 4'd7, -1, 0, 0, "after_reset_run");

    // randomized runs
    for (int i = 0; i < 6; i++) begin
      r_up = 1'($urandom_range(0, 1));
      r_pt = 4'($urandom_range(0, 15));
      r_po = 4'($urandom_range(0, 15));
      n    = 10 * clamp9(r_pt) + clamp9(r_po);
      pa = -1; plen = 0; pj = 1;
      if (n >= 2 && $urandom_range(0, 1) == 1) begin
        pa   = $urandom_range(1, n - 1);
        plen = $urandom_range(1, 12);
        pj   = $urandom_range(1, TICK_DIV);
      end
      run_case(r_up, r_pt, r_po, pa, plen, pj, "random");
    end

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d pending events required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Sequencing controller for a two-digit (tens/ones) chain of 0-9 T-flip-flop BCD counters with enable, reverse and per-bit asynchronous set/clear load. It presets both digits, paces counting with an internal prescaler, cascades the ones carry/borrow into the tens enable, supports pause, and stops exactly at the terminal count. It sits between user control (buttons or CPU strobes) and the two counter instances, which stay outside this block.

## Interface
Parameters:
- TICK_DIV, 4: clocks per count step, ≥1; 1 means a step every enabled cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock, `clk`.
- start  in  1  level; sampled each cycle; (re)starts a run.
- pause  in  1  level; freezes counting while high.
- up_down  in  1  0 = count down from preset to 00; 1 = count up from 00 to preset. Captured on start.
- preset_tens, preset_ones  in  4 each  BCD preset/target. Values 10-15 are clamped to 9 at capture.
- q_tens, q_ones  in  [4:1] each  digit outputs of the counters; Q[1] is the LSB.
- en_tens, en_ones  out  1 each  counter enables.
- rev  out  1  reverse to both counters; 1 = count down.
- load_tens, load_ones  out  8 each  async preset lines. For bit k = 1..4: load[2k-2] is set of Q[k] and load[2k-1] is clear of Q[k]. All zero means normal counting.
- busy  out  1  high in LOAD, RUN, PAUSE.
- done  out  1  high in DONE.

## Operation
- Counter contract: on a clk edge with enable=1, a digit steps +1 mod 10 (rev=0) or −1 mod 10 (rev=1).
- Load encoding of digit d: set line = d bit, clear line = inverted d bit. Examples: 0→8'hAA, 2→8'hA6, 5→8'h99, 9→8'h69.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: all outputs 0. start → LOAD, and capture the clamped preset and up_down.
- LOAD, exactly 1 cycle:
  - load outputs are registered.
  - Down mode drives the preset pattern; up mode drives 00 (8'hAA on both).
  - rev = !up_down, held until the next LOAD or reset.
  - Next state is RUN.
- RUN:
  - Terminal is q == 00 in down mode, or q == captured preset in up mode. It is compared combinationally.
  - en_ones = RUN & tick & !terminal.
  - en_tens = en_ones & (q_ones == 9 in up mode, or == 0 in down mode).
  - Priority: start → LOAD; else terminal → DONE; else pause → PAUSE; else stay.
- PAUSE: enables are 0 and the prescaler is frozen. start → LOAD; pause low → RUN, continuing the prescaler count.
- DONE: enables are 0 and the digits hold the terminal value. start → LOAD.
- A terminal value present on entry to RUN (preset 00 down, or target 00 up) gives DONE the next cycle with zero enable pulses.
- Reset asserted at any time:
  - state IDLE; all outputs 0, including load and rev; prescaler 0.
  - The counters are not cleared by reset. Only LOAD presets them.

## Timing
- Prescaler clears on LOAD. In RUN it counts 0..TICK_DIV−1, and tick = (count == TICK_DIV−1).
- First step is TICK_DIV cycles after RUN entry. Steps are then spaced TICK_DIV cycles apart.
- done rises 1 cycle after the edge where q reaches terminal. No overshoot step occurs.
- start to first load pulse: 1 cycle. The load pulse lasts exactly 1 cycle.
- A pause rising edge suppresses any tick in that same cycle.

## Structure
- Package bcd_timer_pkg holds:
  - state enum type.
  - BCD_MAX = 9.
  - functions bcd_clamp() and bcd_to_load(d), returning the 8-bit pattern.
- Sub-module tick_prescaler: ports clk, reset, clear, run, tick; parameter TICK_DIV.
- The FSM, capture registers, terminal compare and enable logic stay in bcd_timer_ctrl.
- The bench instantiates the controller with two real 0-9 counters.

## Test plan
- Down mode, preset 2/5, TICK_DIV=4:
  - load_tens=8'hA6 and load_ones=8'h99 for one cycle.
  - Exactly 25 en_ones and 2 en_tens pulses (at 20→19 and 10→09).
  - done high with q=00 about 100 cycles after RUN entry.
- Up mode, preset 1/2:
  - Both loads 8'hAA.
  - 12 en_ones pulses and 1 en_tens pulse (09→10); stops at 12.
  - rev=0 throughout.
- Pause held 10 cycles mid-run at q=17:
  - No enable pulses and prescaler frozen.
  - After release, the next step lands exactly the remaining prescaler count later.
- Preset 0/0 down → DONE 1 cycle after RUN with zero enables. Preset 4'hF/4'hC → clamped to 99 (8'h69 on both loads).
- Async reset asserted between clock edges mid-RUN → all outputs 0 immediately, IDLE. A fresh start then reloads correctly.
- start pulsed during RUN at q=13 (down, preset 40) → new load of 40 next cycle, and the count restarts.
